// File: rtl/axi_sram_slave.sv
// AXI3-subset SRAM responder: independent read/write FSMs over a word array.
// Ports: AXI3 AW/W/B/AR/R slave channels on aclk/aresetn; AXI_SLAVE_RDELAY_EN adds first-beat read delay.
module axi_sram_slave #(
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_DELAY   = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  s_axi_awid,
  input  logic [31:0] s_axi_awaddr,
  input  logic [3:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [3:0]  s_axi_wid,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [3:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_arid,
  input  logic [31:0] s_axi_araddr,
  input  logic [3:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [3:0]  s_axi_rid,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

`ifdef AXI_SLAVE_RDELAY_EN
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
`else
  typedef enum logic [1:0] {R_IDLE, R_BURST} r_state_e;
`endif
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [31:0] mem [DEPTH];

  r_state_e r_state, r_state_nxt;
  w_state_e w_state, w_state_nxt;

  logic                  arready_q;
  logic [3:0]            rid_q;
  logic [31:0]           rdata_q;
  logic [3:0]            r_cnt, r_len;
  logic [DEPTH_LOG2-1:0] r_idx, r_idx_inc;

  logic                  awready_q;
  logic [3:0]            bid_q;
  logic                  w_err;
  logic [3:0]            w_cnt, w_len;
  logic [DEPTH_LOG2-1:0] w_idx;

  logic ar_hs, r_hs, r_last;
  logic aw_hs, w_hs, w_end;
  logic [DEPTH_LOG2-1:0] ar_word, aw_word;

  assign ar_word   = s_axi_araddr[DEPTH_LOG2+1:2];
  assign aw_word   = s_axi_awaddr[DEPTH_LOG2+1:2];
  assign r_idx_inc = r_idx + IDX_ONE;

  assign ar_hs  = s_axi_arvalid & arready_q;
  assign r_last = (r_cnt == r_len);
  assign r_hs   = s_axi_rvalid & s_axi_rready;
  assign aw_hs  = s_axi_awvalid & awready_q;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign w_end  = s_axi_wlast | (w_cnt == w_len);

  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr[31:DEPTH_LOG2+2], s_axi_awaddr[1:0],
                         s_axi_araddr[31:DEPTH_LOG2+2], s_axi_araddr[1:0],
                         s_axi_awsize, s_axi_arsize, s_axi_wid};

  // ---------------- read FSM ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

`ifdef AXI_SLAVE_RDELAY_EN
  logic [3:0] r_dcnt;
`else
  logic [3:0] unused_rd_delay;
  assign unused_rd_delay = 4'(RD_DELAY);
`endif

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE: begin
`ifdef AXI_SLAVE_RDELAY_EN
        if (ar_hs) r_state_nxt = R_WAIT;
`else
        if (ar_hs) r_state_nxt = R_BURST;
`endif
      end
`ifdef AXI_SLAVE_RDELAY_EN
      R_WAIT: if (r_dcnt == 4'd0) r_state_nxt = R_BURST;
`endif
      R_BURST: if (r_hs && r_last) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // rdata is fetched on the edge that makes a beat visible, so a
  // same-edge write to that word lands after the read (old data returned).
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arready_q <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
`ifdef AXI_SLAVE_RDELAY_EN
      r_dcnt    <= '0;
`endif
    end else begin
      arready_q <= (r_state_nxt == R_IDLE);
      if (ar_hs) begin
        rid_q <= s_axi_arid;
        r_len <= s_axi_arlen;
        r_cnt <= '0;
        r_idx <= ar_word;
`ifdef AXI_SLAVE_RDELAY_EN
        r_dcnt <= 4'(RD_DELAY - 1);
`else
        rdata_q <= mem[ar_word];
`endif
      end
`ifdef AXI_SLAVE_RDELAY_EN
      if (r_state == R_WAIT) begin
        if (r_dcnt == 4'd0) rdata_q <= mem[r_idx];
        else                r_dcnt  <= r_dcnt - 4'd1;
      end
`endif
      if (r_hs && !r_last) begin
        r_idx   <= r_idx_inc;
        r_cnt   <= r_cnt + 4'd1;
        rdata_q <= mem[r_idx_inc];
      end
    end
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge aclk) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE: if (aw_hs) w_state_nxt = W_DATA;
      W_DATA: if (w_hs && w_end) w_state_nxt = W_RESP;
      W_RESP: if (s_axi_bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      awready_q <= 1'b0;
      bid_q     <= '0;
      w_err     <= 1'b0;
      w_cnt     <= '0;
      w_len     <= '0;
      w_idx     <= '0;
    end else begin
      awready_q <= (w_state_nxt == W_IDLE);
      if (aw_hs) begin
        bid_q <= s_axi_awid;
        w_len <= s_axi_awlen;
        w_cnt <= '0;
        w_idx <= aw_word;
        w_err <= 1'b0;
      end
      if (w_hs) begin
        w_idx <= w_idx + IDX_ONE;
        w_cnt <= w_cnt + 4'd1;
        // wlast and the beat count must agree on where the burst ends
        if (w_end) w_err <= s_axi_wlast ^ (w_cnt == w_len);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn && w_hs) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    s_axi_arready = arready_q;
    s_axi_rvalid  = (r_state == R_BURST);
    s_axi_rlast   = (r_state == R_BURST) && r_last;
    s_axi_rid     = rid_q;
    s_axi_rdata   = rdata_q;
    s_axi_rresp   = 2'b00;
    s_axi_awready = awready_q;
    s_axi_wready  = (w_state == W_DATA);
    s_axi_bvalid  = (w_state == W_RESP);
    s_axi_bid     = bid_q;
    s_axi_bresp   = w_err ? 2'b10 : 2'b00;
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: table of strobed write/readback
// vectors plus hand-written burst, backpressure, wrap and reset sequences.
module tb_axi_sram_slave;

`ifdef AXI_SLAVE_RDELAY_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awlen = '0;
  logic [2:0]  awsize = 3'b010;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [3:0]  arlen = '0;
  logic [2:0]  arsize = 3'b010;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  always #5 aclk = ~aclk;

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_w [16];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic tmo(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: timed out, got no handshake want one", name);
  endtask

  task automatic axi_wr(input string name, input logic [3:0] id,
                        input logic [31:0] addr, input logic [3:0] len,
                        input int nbeats, input int last_beat,
                        input logic [31:0] base, input logic [3:0] strb,
                        input int bdelay, input logic [1:0] exp_resp);
    int n;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    if (n >= 50) tmo({name, " aw"});
    tick();
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      wvalid = 1'b1; wdata = base + 32'(b); wstrb = strb;
      wlast = (b == last_beat);
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      if (n >= 50) tmo({name, " w"});
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) tmo({name, " b"});
    for (int k = 0; k < bdelay; k++) begin
      chk({name, " bvalid held"}, 32'(bvalid), 32'd1);
      tick();
    end
    chk({name, " bid"}, 32'(bid), 32'(id));
    chk({name, " bresp"}, 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk({name, " bvalid drop"}, 32'(bvalid), 32'd0);
    chk({name, " awready back"}, 32'(awready), 32'd1);
  endtask

  task automatic axi_rd(input string name, input logic [3:0] id,
                        input logic [31:0] addr, input logic [3:0] len);
    int n;
    int lat;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (n >= 50) tmo({name, " ar"});
    tick();
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 40) begin tick(); lat++; end
    chk({name, " latency"}, 32'(lat), 32'(LAT));
    rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      chk({name, " rvalid"}, 32'(rvalid), 32'd1);
      chk({name, " rdata"}, rdata, exp_w[b]);
      chk({name, " rlast"}, 32'(rlast), 32'(b == int'(len)));
      chk({name, " rid"}, 32'(rid), 32'(id));
      chk({name, " rresp"}, 32'(rresp), 32'd0);
      tick();
    end
    rready = 1'b0;
    chk({name, " rvalid end"}, 32'(rvalid), 32'd0);
    chk({name, " arready back"}, 32'(arready), 32'd1);
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] pre;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [3:0]  id;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [6];

  initial begin
    int n;
    vt[0] = '{32'h100,  32'h100, 32'h11223344, 32'hAABBCCDD, 4'b0101, 4'h3, 32'h11BB33DD};
    vt[1] = '{32'h104,  32'h104, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 4'h4, 32'hFF000000};
    vt[2] = '{32'h108,  32'h108, 32'h12345678, 32'h00000000, 4'b1111, 4'h5, 32'h00000000};
    vt[3] = '{32'h10C,  32'h10C, 32'hCAFEBABE, 32'h00000000, 4'b0000, 4'h6, 32'hCAFEBABE};
    vt[4] = '{32'h111,  32'h110, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'b0011, 4'h7, 32'hA5A55A5A};
    vt[5] = '{32'h1114, 32'h114, 32'h01020304, 32'hF0F0F0F0, 4'b1010, 4'h8, 32'hF002F004};

    // reset state
    repeat (3) tick();
    chk("rst arready", 32'(arready), 32'd0);
    chk("rst awready", 32'(awready), 32'd0);
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst wready", 32'(wready), 32'd0);
    chk("rst bvalid", 32'(bvalid), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    aresetn = 1'b1;
    chk("rel cycle1 arready", 32'(arready), 32'd0);
    chk("rel cycle1 awready", 32'(awready), 32'd0);
    tick();
    chk("rel cycle2 arready", 32'(arready), 32'd1);
    chk("rel cycle2 awready", 32'(awready), 32'd1);

    // table: preload, strobed write, readback
    for (int i = 0; i < 6; i++) begin
      axi_wr("vec pre", vt[i].id, vt[i].waddr, 4'd0, 1, 0, vt[i].pre, 4'hF, 0, 2'b00);
      axi_wr("vec wr", vt[i].id, vt[i].waddr, 4'd0, 1, 0, vt[i].wd, vt[i].strb, 0, 2'b00);
      exp_w[0] = vt[i].exp;
      axi_rd("vec rd", vt[i].id, vt[i].raddr, 4'd0);
    end

    // single read
    axi_wr("single pre", 4'h2, 32'h40, 4'd0, 1, 0, 32'hDEADBEEF, 4'hF, 0, 2'b00);
    exp_w[0] = 32'hDEADBEEF;
    axi_rd("single rd", 4'h1, 32'h40, 4'd0);

    // bvalid held until bready
    axi_wr("bhold", 4'hC, 32'h120, 4'd0, 1, 0, 32'h13572468, 4'hF, 3, 2'b00);

    // burst read with backpressure on beats 1 and 2
    axi_wr("burst pre", 4'h1, 32'h0, 4'd3, 4, 3, 32'h0, 4'hF, 0, 2'b00);
    arid = 4'h9; araddr = 32'h0; arlen = 4'd3; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 40) begin tick(); n++; end
    chk("bp latency", 32'(n), 32'(LAT));
    for (int b = 0; b < 4; b++) begin
      if (b == 1 || b == 2) begin
        rready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk("bp stall rvalid", 32'(rvalid), 32'd1);
          chk("bp stall rdata", rdata, 32'(b));
          chk("bp stall rlast", 32'(rlast), 32'd0);
          chk("bp stall rid", 32'(rid), 32'h9);
          chk("bp arready busy", 32'(arready), 32'd0);
          if (s < 2) tick();
        end
      end
      chk("bp rdata", rdata, 32'(b));
      chk("bp rlast", 32'(rlast), 32'(b == 3));
      rready = 1'b1;
      tick();
    end
    rready = 1'b0;
    chk("bp rvalid end", 32'(rvalid), 32'd0);
    chk("bp arready turn", 32'(arready), 32'd1);

    // early wlast: 2 of 4 beats, SLVERR
    axi_wr("early pre", 4'h1, 32'h200, 4'd3, 4, 3, 32'h100, 4'hF, 0, 2'b00);
    axi_wr("early wl", 4'hA, 32'h200, 4'd3, 2, 1, 32'hE0, 4'hF, 0, 2'b10);
    exp_w[0] = 32'hE0; exp_w[1] = 32'hE1;
    exp_w[2] = 32'h102; exp_w[3] = 32'h103;
    axi_rd("early rd", 4'h2, 32'h200, 4'd3);

    // missing wlast at the final beat also flags SLVERR
    axi_wr("late wl", 4'hB, 32'h300, 4'd1, 2, 16, 32'h55, 4'hF, 0, 2'b10);
    exp_w[0] = 32'h55; exp_w[1] = 32'h56;
    axi_rd("late rd", 4'h3, 32'h300, 4'd1);

    // wrap plus collision at the top word
    axi_wr("wrap pre top", 4'h1, 32'hFFC, 4'd0, 1, 0, 32'h0BADF00D, 4'hF, 0, 2'b00);
    axi_wr("wrap pre 0", 4'h1, 32'h0, 4'd0, 1, 0, 32'h01234567, 4'hF, 0, 2'b00);
    awid = 4'hD; awaddr = 32'hFFC; awlen = 4'd0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h5555AAAA; wstrb = 4'hF; wlast = 1'b1;
    arid = 4'h5; araddr = 32'hFFC; arlen = 4'd1; arvalid = 1'b1;
    chk("coll wready", 32'(wready), 32'd1);
    chk("coll arready", 32'(arready), 32'd1);
    tick();
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 40) begin tick(); n++; end
    chk("coll latency", 32'(n), 32'(LAT));
`ifdef AXI_SLAVE_RDELAY_EN
    exp_w[0] = 32'h5555AAAA;
`else
    exp_w[0] = 32'h0BADF00D;
`endif
    exp_w[1] = 32'h01234567;
    rready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      chk("coll rdata", rdata, exp_w[b]);
      chk("coll rlast", 32'(rlast), 32'(b == 1));
      tick();
    end
    rready = 1'b0;
    chk("coll bvalid", 32'(bvalid), 32'd1);
    chk("coll bresp", 32'(bresp), 32'd0);
    chk("coll bid", 32'(bid), 32'hD);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    exp_w[0] = 32'h5555AAAA;
    axi_rd("coll reread", 4'h6, 32'hFFC, 4'd0);

    // reset mid-burst
    axi_wr("rst pre", 4'h1, 32'h400, 4'd7, 8, 7, 32'h700, 4'hF, 0, 2'b00);
    arid = 4'h7; araddr = 32'h400; arlen = 4'd7; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 40) begin tick(); n++; end
    rready = 1'b1;
    tick();
    tick();
    chk("rst beat2 data", rdata, 32'h702);
    aresetn = 1'b0;
    tick();
    chk("rst rvalid drop", 32'(rvalid), 32'd0);
    chk("rst arready low", 32'(arready), 32'd0);
    chk("rst awready low", 32'(awready), 32'd0);
    tick();
    rready = 1'b0;
    aresetn = 1'b1;
    chk("rst rel c1 arready", 32'(arready), 32'd0);
    tick();
    chk("rst rel c2 arready", 32'(arready), 32'd1);
    exp_w[0] = 32'h704; exp_w[1] = 32'h705;
    axi_rd("rst after rd", 4'h4, 32'h410, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3-subset responder (slave) backed by an on-chip word-addressed SRAM array.
- Sits on the master port of the 2->1 crossbar and terminates its AR/R/AW/W/B channels, serving as the CPU-side memory/peripheral endpoint in simulation and FPGA bring-up.
- Read and write paths are independent FSMs and may be active simultaneously.
- INCR bursts only, 32-bit data, up to 16 beats.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words in the array (default 1024 words, 4 KiB).
- RD_DELAY, 2, extra cycles between AR handshake and the first R beat; used only when AXI_SLAVE_RDELAY_EN is defined; legal range 1..15.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- s_axi_awid  in  4  write ID
- s_axi_awaddr  in  32  write byte address
- s_axi_awlen  in  4  beats-1
- s_axi_awsize  in  3  must be 3'b010; other values are ignored and treated as 3'b010
- s_axi_awvalid  in  1
- s_axi_awready  out  1
- s_axi_wid  in  4  ignored (no interleaving)
- s_axi_wdata  in  32
- s_axi_wstrb  in  4  byte enables
- s_axi_wlast  in  1
- s_axi_wvalid  in  1
- s_axi_wready  out  1
- s_axi_bid  out  4
- s_axi_bresp  out  2  OKAY=2'b00, SLVERR=2'b10
- s_axi_bvalid  out  1
- s_axi_bready  in  1
- s_axi_arid  in  4
- s_axi_araddr  in  32
- s_axi_arlen  in  4
- s_axi_arsize  in  3  treated as 3'b010
- s_axi_arvalid  in  1
- s_axi_arready  out  1
- s_axi_rid  out  4
- s_axi_rdata  out  32
- s_axi_rresp  out  2  always 2'b00
- s_axi_rlast  out  1
- s_axi_rvalid  out  1
- s_axi_rready  in  1

Behaviour:
- Reset: aclk is the clock; aresetn is a synchronous, active-low reset. While aresetn is low, and in the first cycle it is sampled high, every output is 0. awready and arready are registered and rise the cycle after aresetn is first sampled high. Memory contents are not reset.
- Word index: addr[DEPTH_LOG2+1:2]. Upper bits are ignored, so addresses alias modulo the array size. addr[1:0] is ignored.
- Read FSM states: R_IDLE, R_WAIT, R_BURST.
  - R_IDLE: arready=1. On arvalid&arready, latch arid, word index and arlen; beat counter=0; arready drops next cycle; go to R_BURST, or R_WAIT if the optional feature is enabled.
  - R_BURST: rvalid=1 beginning exactly 1 cycle after the AR handshake. rdata is registered from array[idx]. rid is the latched ID. rlast=1 when counter==len.
  - On rvalid&rready: if not last, idx+1 (wraps at 2^DEPTH_LOG2-1 -> 0), counter+1, next word presented the following cycle with no bubble.
  - rready low: rvalid, rdata, rlast and rid hold stable.
  - Last beat accepted: return to R_IDLE; arready=1 the next cycle, giving a 1-cycle turnaround.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On handshake, latch awid, word index and awlen; counter=0; error flag=0; go to W_DATA.
  - W_DATA: wready=1. On wvalid&wready, write each byte lane i where wstrb[i]=1; lanes with wstrb[i]=0 are unchanged. Then idx+1 (wrapping) and counter+1.
  - Burst end: the burst ends on the beat with wlast=1 or on beat counter==len, whichever comes first. If wlast and (counter==len) disagree, set the error flag. Go to W_RESP.
  - W_RESP: bvalid=1, bid=latched ID, bresp=SLVERR if the error flag is set, else OKAY. bvalid holds until bready. Then go to W_IDLE; awready=1 the next cycle.
- Read/write collision: a read and a write to the same word in the same cycle returns the old data to the read (read-before-write). The written data is visible to any later read beat.
- Outstanding transactions: one read and one write at a time. AW is not accepted while W_DATA or W_RESP is in progress; AR is not accepted while a read burst is in progress.
- Mid-operation reset: an active burst is abandoned and all FSMs return to idle. Partially written data stays in the array.

Optional Feature:
- AXI_SLAVE_RDELAY_EN defined:
  - After AR handshake the read FSM enters R_WAIT and counts RD_DELAY cycles before R_BURST.
  - First rvalid comes 1+RD_DELAY cycles after the handshake.
  - Only the first beat of a burst is delayed; later beats are not.
- Not defined: R_WAIT does not exist; first-beat latency is fixed at 1 cycle.

Test Plan:
- Single read: preload word 0x10 = 0xDEADBEEF; AR addr=0x40, len=0, id=1 -> rvalid 1 cycle later, rdata=0xDEADBEEF, rid=1, rlast=1, rresp=0.
- Read burst with backpressure: words 0..3 = 0..3; AR addr=0, len=3; rready low on beats 1 and 2 for 2 cycles each -> data 0,1,2,3 in order, held stable while stalled, rlast only on beat 3.
- Strobed write: preload 0x11223344; write len=0, wdata=0xAABBCCDD, wstrb=4'b0101 -> word=0x11BB33DD; bid=awid, bresp=OKAY after the W beat; bvalid held until bready.
- Early wlast: AW len=3, wlast asserted on beat 1 -> FSM goes to W_RESP after 2 beats, bresp=2'b10, only 2 words written.
- Wrap plus collision: AR len=1 at the top word (0xFFC with DEPTH_LOG2=10), concurrent write to the top word in the same cycle as the first R beat is read -> beat 0 returns old data, beat 1 returns word 0; a subsequent read of 0xFFC returns the new data.
- Reset mid-burst: assert aresetn low during beat 2 of a len=7 read -> rvalid=0 at once; arready=1 the 2nd cycle after release; a new read completes normally. With AXI_SLAVE_RDELAY_EN and RD_DELAY=2, first rvalid arrives 3 cycles after the AR handshake.
